// File: rtl/mem_store_ctrl.sv
// Store-side writer for the MEM stage: lane-positions one store onto a 32-bit
// word-addressed write port, splitting word-crossing stores into two beats.
module mem_store_ctrl #(
  parameter int WordSize = 32,
  parameter int AddrSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [AddrSize-1:0] st_addr,
  input  logic [WordSize-1:0] st_data,
  input  logic [1:0]          st_size,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [AddrSize-1:0] mem_addr,
  output logic [WordSize-1:0] mem_wdata,
  output logic [3:0]          mem_be,
  output logic                st_done,
  output logic                st_err,
  output logic                stall,
  output logic [1:0]          dbg_state
);

  // Handshake: a store is taken on any clk edge where st_valid && st_ready;
  // st_ready is high only in IDLE and the request fields must be stable while valid.
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [AddrSize-1:0]   mem_addr_q, mem_addr_d;
  logic [WordSize-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  st_done_q, st_done_d;
  logic                  st_err_q, st_err_d;
  logic [AddrSize-1:0]   hi_addr_q, hi_addr_d;
  logic [WordSize-1:0]   hi_wdata_q, hi_wdata_d;
  logic [3:0]            hi_be_q, hi_be_d;

  logic [1:0]            off;
  logic [3:0]            mask;
  logic [WordSize-1:0]   data_masked;
  logic [2*WordSize-1:0] d64;
  logic [7:0]            be8;
  logic [AddrSize-1:0]   base;

  always_comb begin
    off = st_addr[1:0];
    case (st_size)
      2'd0:    mask = 4'h1;
      2'd1:    mask = 4'h3;
      default: mask = 4'hF;
    endcase
    data_masked = st_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    d64  = {{WordSize{1'b0}}, data_masked} << {off, 3'b000};
    be8  = {4'b0000, mask} << off;
    base = {st_addr[AddrSize-1:2], 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    hi_addr_d   = hi_addr_q;
    hi_wdata_d  = hi_wdata_q;
    hi_be_d     = hi_be_q;
    st_done_d   = 1'b0;
    st_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (st_size == 2'd3) begin
            st_err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_req_d   = 1'b1;
            mem_addr_d  = base;
            mem_be_d    = be8[3:0];
            mem_wdata_d = d64[WordSize-1:0];
            hi_addr_d   = base + AddrSize'(4);
            hi_be_d     = be8[7:4];
            hi_wdata_d  = d64[2*WordSize-1:WordSize];
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (hi_be_q != 4'h0) begin
            state_d     = BEAT1;
            mem_addr_d  = hi_addr_q;
            mem_be_d    = hi_be_q;
            mem_wdata_d = hi_wdata_q;
          end else begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_be_d    = 4'h0;
            mem_wdata_d = '0;
            st_done_d   = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_be_d    = 4'h0;
          mem_wdata_d = '0;
          st_done_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_be_d  = 4'h0;
      end
    endcase
  end

  // Reset mid-store drops the transfer outright; nothing is replayed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'h0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      hi_addr_q   <= '0;
      hi_wdata_q  <= '0;
      hi_be_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
      hi_addr_q   <= hi_addr_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_be_q     <= hi_be_d;
    end
  end

  assign st_ready  = (state_q == IDLE);
  assign stall     = st_valid && !st_ready;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Bench for mem_store_ctrl: a byte-by-byte reference model predicts every
// memory beat, checked against directed and random stores.
module tb_mem_store_ctrl;

  logic        clk;
  logic        rstn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;
  logic        stall;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  mem_store_ctrl #(.WordSize(32), .AddrSize(32)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .st_done(st_done), .st_err(st_err), .stall(stall),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each stored byte lands at byte address addr+i; group bytes by the word they hit.
  function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, output int nb,
                                output logic [31:0] a0, output logic [31:0] a1,
                                output logic [3:0] b0, output logic [3:0] b1,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] ba;
    logic [31:0] base;
    int n;
    n = 1 << size;
    base = addr & 32'hFFFF_FFFC;
    a0 = base;
    a1 = base + 32'd4;
    b0 = 4'h0; b1 = 4'h0; w0 = 32'h0; w1 = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = addr + i;
      if ((ba & 32'hFFFF_FFFC) == base) begin
        b0[ba[1:0]] = 1'b1;
        w0[8*ba[1:0] +: 8] = data[8*i +: 8];
      end else begin
        b1[ba[1:0]] = 1'b1;
        w1[8*ba[1:0] +: 8] = data[8*i +: 8];
      end
    end
    nb = (b1 != 4'h0) ? 2 : 1;
  endfunction

  // Presents one store, serves each beat after d0/d1 wait cycles, checks every cycle.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input int d0, input int d1,
                           input bit hold);
    int nb;
    int dl;
    logic [31:0] ea[2];
    logic [31:0] ew[2];
    logic [3:0]  eb[2];
    model(addr, data, size, nb, ea[0], ea[1], eb[0], eb[1], ew[0], ew[1]);
    st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
    #1;
    checks++;
    if (st_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL accept_ready addr=%h ready=%b stall=%b required ready=1 stall=0", addr, st_ready, stall);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      dl = (k == 0) ? d0 : d1;
      for (int j = 0; j <= dl; j++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== ea[k] || mem_be !== eb[k] ||
            mem_wdata !== ew[k] || st_done !== 1'b0 || st_ready !== 1'b0) begin
          failures++;
          $display("FAIL beat%0d st_addr=%h wait=%0d got req=%b addr=%h be=%h wdata=%h done=%b rdy=%b required req=1 addr=%h be=%h wdata=%h done=0 rdy=0",
                   k, addr, j, mem_req, mem_addr, mem_be, mem_wdata, st_done, st_ready, ea[k], eb[k], ew[k]);
        end
        if (j < dl) begin
          mem_ack = 1'b0;
          if (hold) begin
            st_valid = 1'b1;
            #1;
            checks++;
            if (stall !== 1'b1 || st_ready !== 1'b0) begin
              failures++;
              $display("FAIL stall_hold got stall=%b ready=%b required stall=1 ready=0", stall, st_ready);
            end
            st_valid = 1'b0;
          end
          @(posedge clk); #1;
        end else begin
          mem_ack = 1'b1;
          @(posedge clk); #1;
          mem_ack = 1'b0;
        end
      end
    end
    checks++;
    if (st_done !== 1'b1 || mem_req !== 1'b0 || mem_be !== 4'h0 ||
        mem_wdata !== 32'h0 || st_ready !== 1'b1 || st_err !== 1'b0) begin
      failures++;
      $display("FAIL done st_addr=%h got done=%b req=%b be=%h wdata=%h rdy=%b err=%b required done=1 req=0 be=0 wdata=0 rdy=1 err=0",
               addr, st_done, mem_req, mem_be, mem_wdata, st_ready, st_err);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; st_valid = 1'b0; mem_ack = 1'b0;
    st_addr = 32'h0; st_data = 32'h0; st_size = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 ||
        st_done !== 1'b0 || st_err !== 1'b0 || st_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got req=%b addr=%h wdata=%h be=%h done=%b err=%b rdy=%b stall=%b required all 0 except rdy=1",
               mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err, st_ready, stall);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_store(32'h0000_1000, 32'hDEAD_BEEF, 2'd2, 0, 0, 1'b0);
    run_store(32'h0000_1003, 32'h0000_00A5, 2'd0, 0, 0, 1'b0);
    run_store(32'h0000_2003, 32'h0000_BEEF, 2'd1, 0, 0, 1'b0);
    run_store(32'hFFFF_FFFE, 32'h1122_3344, 2'd2, 0, 0, 1'b0);
    // upper bytes of st_data must not leak into unused lanes
    run_store(32'h0000_3001, 32'hFFFF_FF5A, 2'd0, 0, 0, 1'b0);
    run_store(32'h0000_3002, 32'hABCD_1234, 2'd1, 0, 0, 1'b0);
  endtask

  task automatic test_delayed_ack();
    run_store(32'h0000_4000, 32'hCAFE_F00D, 2'd2, 3, 0, 1'b1);
    run_store(32'h0000_4001, 32'h0BAD_F00D, 2'd2, 3, 2, 1'b1);
  endtask

  task automatic test_illegal_size();
    st_valid = 1'b1; st_addr = 32'h0000_5000; st_data = 32'h1234_5678; st_size = 2'd3;
    @(posedge clk); #1;
    st_valid = 1'b0;
    checks++;
    if (st_err !== 1'b1 || mem_req !== 1'b0 || st_ready !== 1'b1 || st_done !== 1'b0) begin
      failures++;
      $display("FAIL illegal_err got err=%b req=%b rdy=%b done=%b required err=1 req=0 rdy=1 done=0", st_err, mem_req, st_ready, st_done);
    end
    @(posedge clk); #1;
    checks++;
    if (st_err !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse got err=%b req=%b required err=0 req=0", st_err, mem_req);
    end
  endtask

  task automatic test_ack_ignored();
    mem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b0 || st_done !== 1'b0 || st_ready !== 1'b1) begin
        failures++;
        $display("FAIL ack_idle got req=%b done=%b rdy=%b required req=0 done=0 rdy=1", mem_req, st_done, st_ready);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    st_valid = 1'b1; st_addr = 32'h0000_2003; st_data = 32'h0000_BEEF; st_size = 2'd1;
    @(posedge clk); #1;
    st_valid = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2004 || mem_be !== 4'h1) begin
      failures++;
      $display("FAIL mid_beat1 got req=%b addr=%h be=%h required req=1 addr=00002004 be=1", mem_req, mem_addr, mem_be);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_be !== 4'h0 || st_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got req=%b be=%h rdy=%b required req=0 be=0 rdy=1", mem_req, mem_be, st_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b0 || st_done !== 1'b0) begin
        failures++;
        $display("FAIL post_reset got req=%b done=%b required req=0 done=0", mem_req, st_done);
      end
    end
    run_store(32'h0000_6002, 32'h5566_7788, 2'd2, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_store(a, $urandom, 2'($urandom_range(0, 2)),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_delayed_ack();
    test_illegal_size();
    test_ack_ignored();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
